// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM states, SPI mode encodings and
// the slave-select index width.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      XFER  = 3'd2,
      TRAIL = 3'd3,
      GAP   = 3'd4
   } spi_state_e;

   // Mode encodings are {cpol, cpha}.
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Leaves room for at least one index >= n_ss, which runs a frame with no slave selected.
   function automatic int sel_width(input int n_ss);
      return $clog2(n_ss + 1);
   endfunction

endpackage

// File: rtl/spi_master_if.sv
// Bundle of the SPI master's host-side handshake and serial pins.
// The master modport is the controller's view; slave is the host/bus view.
interface spi_master_if #(
   parameter int W_DATA = 32,
   parameter int N_SS   = 4,
   parameter int W_DIV  = 8
) ();
   import spi_pkg::*;

   localparam int SS_W = sel_width(N_SS);

   logic [W_DATA-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [SS_W-1:0]   ss_sel;
   logic              cpol;
   logic              cpha;
   logic [W_DIV-1:0]  clk_div;
   logic [W_DATA-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
   logic              sclk;
   logic              mosi;
   logic              miso;
   logic [N_SS-1:0]   ss_n;

   modport master (
      input  tx_data, tx_valid, ss_sel, cpol, cpha, clk_div, miso,
      output tx_ready, rx_data, rx_valid, busy, sclk, mosi, ss_n
   );

   modport slave (
      output tx_data, tx_valid, ss_sel, cpol, cpha, clk_div, miso,
      input  tx_ready, rx_data, rx_valid, busy, sclk, mosi, ss_n
   );

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period timer: strobes done_o every div_i+1 cycles while run_i is high
// and toggles phase_o on each strobe; both restart from zero when run_i drops.
module spi_clk_gen #(
   parameter int W_DIV = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W_DIV-1:0] div_i,
   input  logic             run_i,
   output logic             done_o,
   output logic             phase_o
);

   logic [W_DIV-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;

   // The counter never passes div_i, so an all-ones divider cannot wrap.
   assign done_o  = run_i && (cnt_q == div_i);
   assign phase_o = phase_q;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (!run_i) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (done_o) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d   = cnt_q + W_DIV'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/spi_master.sv
// Single-frame SPI master: latches a frame and its mode on accept, then runs
// LEAD/XFER/TRAIL/GAP with all outputs registered.
module spi_master
   import spi_pkg::*;
#(
   parameter int W_DATA = 32,
   parameter int N_SS   = 4,
   parameter int W_DIV  = 8
) (
   input  logic         clk,
   input  logic         rst,
   spi_master_if.master bus
);

   localparam int W_BCNT = $clog2(W_DATA) + 1;
   localparam int SS_W   = sel_width(N_SS);

   spi_state_e        state_q;
   logic [W_DATA-1:0] tx_shift_q;
   logic [W_DATA-1:0] rx_shift_q;
   logic [W_DATA-1:0] rx_data_q;
   logic [W_BCNT-1:0] bit_cnt_q;
   logic [W_DIV-1:0]  div_q;
   logic [N_SS-1:0]   ss_n_q;
   logic              cpol_q;
   logic              cpha_q;
   logic              sclk_q;
   logic              mosi_q;
   logic              tx_ready_q;
   logic              busy_q;
   logic              fire_q;
   logic              rx_valid_q;

   logic              run;
   logic              hp_done;
   logic              phase;
   logic              accept;
   logic              lead_edge;
   logic              trail_edge;
   logic              xfer_last;
   logic              launch;
   logic              sample;
   logic [N_SS-1:0]   sel_dec;

   assign run = (state_q != IDLE);

   spi_clk_gen #(
      .W_DIV (W_DIV)
   ) u_clk_gen (
      .clk     (clk),
      .rst     (rst),
      .div_i   (div_q),
      .run_i   (run),
      .done_o  (hp_done),
      .phase_o (phase)
   );

   // Out-of-range indices match no line, so the frame runs fully deselected.
   for (genvar gi = 0; gi < N_SS; gi++) begin : g_sel
      assign sel_dec[gi] = (bus.ss_sel != SS_W'(gi));
   end

   // phase is high during the half-periods that follow a leading edge.
   assign accept     = tx_ready_q && bus.tx_valid;
   assign trail_edge = hp_done && (state_q == XFER) && phase;
   assign xfer_last  = hp_done && (state_q == XFER) && !phase
                       && (bit_cnt_q == W_BCNT'(W_DATA));
   assign lead_edge  = hp_done && ((state_q == LEAD)
                       || ((state_q == XFER) && !phase && !xfer_last));
   assign launch     = cpha_q ? lead_edge  : trail_edge;
   assign sample     = cpha_q ? trail_edge : lead_edge;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         bit_cnt_q  <= '0;
         div_q      <= '0;
         ss_n_q     <= '1;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         fire_q     <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         fire_q     <= 1'b0;
         rx_valid_q <= fire_q;
         if (fire_q) begin
            rx_data_q <= rx_shift_q;
         end
         if (launch) begin
            mosi_q     <= tx_shift_q[W_DATA-1];
            tx_shift_q <= tx_shift_q << 1;
         end
         if (sample) begin
            rx_shift_q <= {rx_shift_q[W_DATA-2:0], bus.miso};
         end
         if (trail_edge) begin
            bit_cnt_q <= bit_cnt_q + W_BCNT'(1);
         end

         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q    <= LEAD;
                  tx_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  cpol_q     <= bus.cpol;
                  cpha_q     <= bus.cpha;
                  div_q      <= bus.clk_div;
                  ss_n_q     <= sel_dec;
                  sclk_q     <= bus.cpol;
                  rx_shift_q <= '0;
                  bit_cnt_q  <= '0;
                  // cpha=0 puts the MSB out now; cpha=1 waits for the first leading edge.
                  mosi_q     <= bus.cpha ? 1'b0 : bus.tx_data[W_DATA-1];
                  tx_shift_q <= bus.cpha ? bus.tx_data : (bus.tx_data << 1);
               end
            end
            LEAD: begin
               if (hp_done) begin
                  state_q <= XFER;
                  sclk_q  <= ~cpol_q;
               end
            end
            XFER: begin
               if (hp_done) begin
                  if (xfer_last) begin
                     state_q <= TRAIL;
                  end else begin
                     sclk_q  <= ~sclk_q;
                  end
               end
            end
            TRAIL: begin
               if (hp_done) begin
                  state_q <= GAP;
                  ss_n_q  <= '1;
                  mosi_q  <= 1'b0;
                  fire_q  <= 1'b1;
               end
            end
            GAP: begin
               if (hp_done) begin
                  state_q    <= IDLE;
                  tx_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.tx_ready = tx_ready_q;
   assign bus.busy     = busy_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.sclk     = sclk_q;
   assign bus.mosi     = mosi_q;
   assign bus.ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with W_DATA=8, N_SS=4: modes, timing, select
// decode, back-to-back frames and reset abort.
module tb_spi_master;
   import spi_pkg::*;

   logic       clk;
   logic       rst;
   logic       miso_high;
   int         cyc     = 0;
   int         n_pass  = 0;
   int         n_total = 0;
   int         n_lead;
   int         n_trail;
   logic [3:0] ss_and;

   spi_master_if #(.W_DATA(8), .N_SS(4), .W_DIV(8)) bus ();

   spi_master #(.W_DATA(8), .N_SS(4), .W_DIV(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.miso = miso_high ? 1'b1 : bus.mosi;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic start_frame(input logic [7:0] d, input logic [2:0] sel, input logic [1:0] mode,
                              input logic [7:0] div, input bit hold, output int t_acc);
      int w;
      @(negedge clk);
      bus.tx_data  = d;
      bus.ss_sel   = sel;
      bus.cpol     = mode[1];
      bus.cpha     = mode[0];
      bus.clk_div  = div;
      bus.tx_valid = 1'b1;
      w = 0;
      while (bus.tx_ready !== 1'b1 && w < 300) begin
         @(negedge clk);
         w++;
      end
      n_total++;
      if (bus.tx_ready !== 1'b1) $display("FAIL accept_wait: tx_ready got %b required 1", bus.tx_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      if (!hold) bus.tx_valid = 1'b0;
      t_acc = cyc;
   endtask

   task automatic run_frame(input logic [7:0] tx, input logic cpol, input logic cpha,
                            input bit chk_mosi, output int t_rv);
      logic prev;
      logic exp;
      prev    = cpol;
      n_lead  = 0;
      n_trail = 0;
      ss_and  = 4'hF;
      t_rv    = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         ss_and = ss_and & bus.ss_n;
         if (bus.sclk !== prev) begin
            if (bus.sclk !== cpol) begin
               if (chk_mosi && n_lead < 8) begin
                  exp = tx[7-n_lead];
                  n_total++;
                  if (bus.mosi !== exp) $display("FAIL mosi_lead%0d: got %b required %b", n_lead, bus.mosi, exp);
                  else n_pass++;
               end
               n_lead++;
            end else begin
               if (chk_mosi && n_trail < 8 && (cpha || n_trail < 7)) begin
                  exp = cpha ? tx[7-n_trail] : tx[6-n_trail];
                  n_total++;
                  if (bus.mosi !== exp) $display("FAIL mosi_trail%0d: got %b required %b", n_trail, bus.mosi, exp);
                  else n_pass++;
               end
               n_trail++;
            end
         end
         prev = bus.sclk;
         if (bus.rx_valid === 1'b1) begin
            t_rv = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int t;
      rst = 1'b0;
      bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.ss_sel = 3'd0;
      bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = 8'd0;
      repeat (2) @(negedge clk);
      n_total += 7;
      if (bus.tx_ready !== 1'b1) $display("FAIL rst_tx_ready: got %b required 1", bus.tx_ready); else n_pass++;
      if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", bus.busy); else n_pass++;
      if (bus.rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b required 0", bus.rx_valid); else n_pass++;
      if (bus.rx_data !== 8'h00) $display("FAIL rst_rx_data: got %h required 00", bus.rx_data); else n_pass++;
      if (bus.mosi !== 1'b0) $display("FAIL rst_mosi: got %b required 0", bus.mosi); else n_pass++;
      if (bus.ss_n !== 4'hF) $display("FAIL rst_ss_n: got %b required 1111", bus.ss_n); else n_pass++;
      if (bus.sclk !== 1'b0) $display("FAIL rst_sclk: got %b required 0", bus.sclk); else n_pass++;
      // Release reset with a frame already offered: it must be taken on the first edge.
      bus.tx_data = 8'h5A; bus.clk_div = 8'd1; bus.tx_valid = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
      n_total += 2;
      if (bus.busy !== 1'b1) $display("FAIL first_edge_busy: got %b required 1", bus.busy); else n_pass++;
      if (bus.tx_ready !== 1'b0) $display("FAIL first_edge_ready: got %b required 0", bus.tx_ready); else n_pass++;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      n_total += 2;
      if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b required 0", bus.busy); else n_pass++;
      if (bus.ss_n !== 4'hF) $display("FAIL abort_ss_n: got %b required 1111", bus.ss_n); else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      t = 0;
   endtask

   task automatic test_mode0();
      int t_acc, t_rv;
      miso_high = 1'b0;
      start_frame(8'hA5, 3'd2, MODE0, 8'd1, 1'b0, t_acc);
      n_total += 3;
      if (bus.tx_ready !== 1'b0) $display("FAIL m0_ready: got %b required 0", bus.tx_ready); else n_pass++;
      if (bus.busy !== 1'b1) $display("FAIL m0_busy: got %b required 1", bus.busy); else n_pass++;
      if (bus.ss_n !== 4'b1011) $display("FAIL m0_ss_n_lead: got %b required 1011", bus.ss_n); else n_pass++;
      run_frame(8'hA5, 1'b0, 1'b0, 1'b1, t_rv);
      n_total += 5;
      if (t_rv - t_acc !== 37) $display("FAIL m0_latency: got %0d required 37", t_rv - t_acc); else n_pass++;
      if (bus.rx_data !== 8'hA5) $display("FAIL m0_rx_data: got %h required a5", bus.rx_data); else n_pass++;
      if (ss_and !== 4'b1011) $display("FAIL m0_ss_n_frame: got %b required 1011", ss_and); else n_pass++;
      if (n_lead !== 8) $display("FAIL m0_lead_edges: got %0d required 8", n_lead); else n_pass++;
      if (n_trail !== 8) $display("FAIL m0_trail_edges: got %0d required 8", n_trail); else n_pass++;
      @(negedge clk);
      n_total += 2;
      if (bus.rx_valid !== 1'b0) $display("FAIL m0_rv_pulse: got %b required 0", bus.rx_valid); else n_pass++;
      if (bus.rx_data !== 8'hA5) $display("FAIL m0_rx_hold: got %h required a5", bus.rx_data); else n_pass++;
      @(negedge clk);
      n_total += 4;
      if (bus.busy !== 1'b0) $display("FAIL m0_idle_busy: got %b required 0", bus.busy); else n_pass++;
      if (bus.ss_n !== 4'hF) $display("FAIL m0_idle_ss_n: got %b required 1111", bus.ss_n); else n_pass++;
      if (bus.mosi !== 1'b0) $display("FAIL m0_idle_mosi: got %b required 0", bus.mosi); else n_pass++;
      if (bus.sclk !== 1'b0) $display("FAIL m0_idle_sclk: got %b required 0", bus.sclk); else n_pass++;
   endtask

   task automatic test_mode3();
      int t_acc, t_rv;
      miso_high = 1'b1;
      start_frame(8'h3C, 3'd0, MODE3, 8'd0, 1'b0, t_acc);
      n_total++;
      if (bus.sclk !== 1'b1) $display("FAIL m3_sclk_lead: got %b required 1", bus.sclk); else n_pass++;
      run_frame(8'h3C, 1'b1, 1'b1, 1'b1, t_rv);
      n_total += 4;
      if (t_rv - t_acc !== 19) $display("FAIL m3_latency: got %0d required 19", t_rv - t_acc); else n_pass++;
      if (bus.rx_data !== 8'hFF) $display("FAIL m3_rx_data: got %h required ff", bus.rx_data); else n_pass++;
      if (n_trail !== 8) $display("FAIL m3_rising_edges: got %0d required 8", n_trail); else n_pass++;
      if (bus.sclk !== 1'b1) $display("FAIL m3_sclk_idle: got %b required 1", bus.sclk); else n_pass++;
      miso_high = 1'b0;
   endtask

   task automatic test_modes12();
      int t_acc, t_rv;
      start_frame(8'h81, 3'd1, MODE1, 8'd2, 1'b0, t_acc);
      run_frame(8'h81, 1'b0, 1'b1, 1'b1, t_rv);
      n_total += 2;
      if (t_rv - t_acc !== 55) $display("FAIL m1_latency: got %0d required 55", t_rv - t_acc); else n_pass++;
      if (bus.rx_data !== 8'h81) $display("FAIL m1_rx_data: got %h required 81", bus.rx_data); else n_pass++;
      start_frame(8'h81, 3'd3, MODE2, 8'd1, 1'b0, t_acc);
      run_frame(8'h81, 1'b1, 1'b0, 1'b1, t_rv);
      n_total += 3;
      if (t_rv - t_acc !== 37) $display("FAIL m2_latency: got %0d required 37", t_rv - t_acc); else n_pass++;
      if (bus.rx_data !== 8'h81) $display("FAIL m2_rx_data: got %h required 81", bus.rx_data); else n_pass++;
      if (ss_and !== 4'b0111) $display("FAIL m2_ss_n_frame: got %b required 0111", ss_and); else n_pass++;
   endtask

   task automatic test_bad_sel();
      int t_acc, t_rv;
      start_frame(8'hC3, 3'd5, MODE0, 8'd1, 1'b0, t_acc);
      n_total++;
      if (bus.ss_n !== 4'hF) $display("FAIL sel5_ss_n_lead: got %b required 1111", bus.ss_n); else n_pass++;
      run_frame(8'hC3, 1'b0, 1'b0, 1'b0, t_rv);
      n_total += 4;
      if (ss_and !== 4'hF) $display("FAIL sel5_ss_n_frame: got %b required 1111", ss_and); else n_pass++;
      if (t_rv - t_acc !== 37) $display("FAIL sel5_latency: got %0d required 37", t_rv - t_acc); else n_pass++;
      if (n_lead !== 8) $display("FAIL sel5_lead_edges: got %0d required 8", n_lead); else n_pass++;
      if (bus.rx_data !== 8'hC3) $display("FAIL sel5_rx_data: got %h required c3", bus.rx_data); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int         t_acc, n_rx, n_acc, hi_run, gap;
      bit         seen_low;
      logic [7:0] got [2];
      got[0] = 8'h00; got[1] = 8'h00;
      n_rx = 0; n_acc = 1; hi_run = 0; gap = -1; seen_low = 1'b0;
      start_frame(8'h01, 3'd1, MODE0, 8'd1, 1'b1, t_acc);
      bus.tx_data = 8'h02;
      for (int i = 0; i < 200 && n_rx < 2; i++) begin
         @(negedge clk);
         if (bus.ss_n !== 4'hF) begin
            if (seen_low && hi_run > 0 && gap < 0) gap = hi_run;
            hi_run = 0;
            seen_low = 1'b1;
         end else if (seen_low) begin
            hi_run++;
         end
         if (bus.rx_valid === 1'b1) begin
            got[n_rx] = bus.rx_data;
            n_rx++;
         end
         if (bus.tx_ready === 1'b1 && n_acc == 1) begin
            @(posedge clk);
            #1;
            bus.tx_valid = 1'b0;
            n_acc = 2;
         end
      end
      n_total += 4;
      if (n_rx !== 2) $display("FAIL b2b_pulses: got %0d required 2", n_rx); else n_pass++;
      if (got[0] !== 8'h01) $display("FAIL b2b_rx0: got %h required 01", got[0]); else n_pass++;
      if (got[1] !== 8'h02) $display("FAIL b2b_rx1: got %h required 02", got[1]); else n_pass++;
      if (gap < 2) $display("FAIL b2b_ss_gap: got %0d required >=2", gap); else n_pass++;
      repeat (4) @(negedge clk);
      n_total++;
      if (bus.busy !== 1'b0) $display("FAIL b2b_no_third: got %b required 0", bus.busy); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int   t_acc, t_rv, falls;
      logic prev;
      bit   rv_seen;
      start_frame(8'h77, 3'd0, MODE0, 8'd1, 1'b0, t_acc);
      falls = 0; prev = 1'b0; rv_seen = 1'b0;
      for (int i = 0; i < 100 && falls < 4; i++) begin
         @(negedge clk);
         if (prev === 1'b1 && bus.sclk === 1'b0) falls++;
         prev = bus.sclk;
      end
      n_total++;
      if (falls !== 4) $display("FAIL mid_reach_bit4: got %0d required 4", falls); else n_pass++;
      rst = 1'b0;
      #1;
      n_total += 7;
      if (bus.busy !== 1'b0) $display("FAIL mid_busy: got %b required 0", bus.busy); else n_pass++;
      if (bus.tx_ready !== 1'b1) $display("FAIL mid_ready: got %b required 1", bus.tx_ready); else n_pass++;
      if (bus.ss_n !== 4'hF) $display("FAIL mid_ss_n: got %b required 1111", bus.ss_n); else n_pass++;
      if (bus.sclk !== 1'b0) $display("FAIL mid_sclk: got %b required 0", bus.sclk); else n_pass++;
      if (bus.mosi !== 1'b0) $display("FAIL mid_mosi: got %b required 0", bus.mosi); else n_pass++;
      if (bus.rx_data !== 8'h00) $display("FAIL mid_rx_data: got %h required 00", bus.rx_data); else n_pass++;
      if (bus.rx_valid !== 1'b0) $display("FAIL mid_rx_valid: got %b required 0", bus.rx_valid); else n_pass++;
      repeat (3) begin
         @(negedge clk);
         if (bus.rx_valid !== 1'b0) rv_seen = 1'b1;
      end
      rst = 1'b1;
      n_total++;
      if (rv_seen) $display("FAIL mid_no_rv: got 1 required 0"); else n_pass++;
      start_frame(8'h55, 3'd3, MODE0, 8'd1, 1'b0, t_acc);
      run_frame(8'h55, 1'b0, 1'b0, 1'b0, t_rv);
      n_total += 2;
      if (t_rv - t_acc !== 37) $display("FAIL mid_next_latency: got %0d required 37", t_rv - t_acc); else n_pass++;
      if (bus.rx_data !== 8'h55) $display("FAIL mid_next_rx: got %h required 55", bus.rx_data); else n_pass++;
   endtask

   initial begin
      miso_high = 1'b0;
      test_reset();
      test_mode0();
      test_mode3();
      test_modes12();
      test_bad_sel();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
